bicubic_rsp_collector: RTL and testbench
========================================

// Module: bicubic_rsp_collector
// PURPOSE
//  Sits directly downstream of the 2x bicubic upsample stage. Each accepted beat carries two upsampled rows of 4 pixels
//  (lanes 0-3 = row A, lanes 4-7 = row B). The block buffers these beats and reissues them one row (4 pixels) per beat.
//  Each row is tagged with its row index within the 4-row output block and flags the block's last row.
//  Decouples upsample throughput from the output writer's backpressure.
// PARAMETERS
//  CHANNEL_WIDTH  8  bits per pixel channel
//  FIFO_DEPTH     4  buffered input beats (8 pixels each); power of 2, >=2
// PORTS
//  clk              in   1          single clock; all flops rising edge
//  rst              in   1          asynchronous, active-high reset
//  bcci_rsp_valid   in   1          upsample beat valid
//  bcci_rsp_ready   out  1          collector can accept a beat
//  bcci_rsp_data    in   8*CW       lane k = [CW*k +: CW]; lanes 0-3 row A, lanes 4-7 row B
//  out_valid        out  1          output row valid
//  out_ready        in   1          downstream accepts row
//  out_data         out  4*CW       4 pixels of one output row, pixel 0 in LSBs
//  out_row          out  2          row index 0..3 within the current 4-row block
//  out_last         out  1          high when out_row==3
//  stall_cnt        out  16         only with BCCI_COLLECT_STAT_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: FIFO empty; wr_ptr, rd_ptr, count cleared; half=0; in_phase=0; bcci_rsp_ready=1.
//    Also out_valid=0, out_data=0, out_row=0, out_last=0, stall_cnt=0.
//  - Input handshake: push when bcci_rsp_valid & bcci_rsp_ready.
//    The entry stores the 8 lanes plus in_phase. in_phase toggles on every push.
//    Phase 0 = upsample S1 beat (rows 0,1); phase 1 = S2 beat (rows 2,3).
//  - bcci_rsp_ready = (count != FIFO_DEPTH). It depends only on registered count, not on out_ready.
//    No pass-through when full: a pop and a blocked push in the same cycle do not push.
//  - Output: out_valid = (count != 0). out_data/out_row/out_last are combinational from the head entry and the half flag.
//    half=0 -> lanes 0-3, out_row = {phase,1'b0}; half=1 -> lanes 4-7, out_row = {phase,1'b1}.
//  - Output handshake: on out_valid & out_ready, half toggles. When half was 1, the head entry pops (rd_ptr++, count--).
//    Each entry therefore yields exactly 2 output beats.
//  - Simultaneous push and pop (not full): count unchanged, both pointers advance.
//  - Pointers wrap modulo FIFO_DEPTH. count is log2(DEPTH)+1 bits wide.
//  - Latency: a beat pushed in cycle N appears as out_valid in N+1 (empty FIFO).
//    Sustained throughput is 1 input beat per 2 cycles, matching 2 output rows per beat.
//  - Output stall: with out_valid high and out_ready low, all output fields hold stable.
//  - Reset mid-operation clears all state immediately. Buffered pixels are discarded and in_phase restarts at 0.
// CONFIGURATION
//  - `BCCI_COLLECT_STAT_EN defined: adds port stall_cnt.
//    It is a 16-bit saturating count of cycles with out_valid & ~out_ready. It holds at 16'hFFFF and is cleared only by rst.
//  - Macro undefined: the port and its counter do not exist; all other behaviour is identical.
// STRUCTURE
//  - define.v: CHANNEL_WIDTH, PIX_PER_ROW=4, ROWS_PER_BLK=4 shared with the upsample stage.
//  - Sub-module bcci_sync_fifo: storage, pointers, count, full/empty; width 8*CW+1, depth FIFO_DEPTH.
//  - Top level holds in_phase, the half flag, the row mux and the optional stat counter.
// TESTING
//  1. Reset then idle -> bcci_rsp_ready=1, out_valid=0, out_row=0, stall_cnt=0.
//  2. Push one beat, lanes 0x01..0x08, out_ready=1 -> next cycle out_data={04,03,02,01}, row 0.
//     The following cycle gives {08,07,06,05}, row 1. Then out_valid=0.
//  3. Push 2 beats back-to-back, out_ready=1 -> rows 0,1,2,3 in order; out_last=1 only on row 3.
//  4. out_ready=0, push 5 beats with DEPTH=4 -> ready drops after the 4th push and the 5th is held by the source.
//     Raise out_ready -> 8 rows drain; the 5th beat is then accepted as phase 0.
//  5. Push while popping the last half of the head entry in the same cycle -> count unchanged, no row lost or duplicated.
//  6. Assert rst mid-stream with 3 entries queued -> out_valid=0 immediately; the next push emits row 0.
//     With STAT_EN, 20 stall cycles -> stall_cnt=20.

Source files
------------

// File: rtl/bicubic_rsp_collector_pkg.sv
// Shared constants and types for the bicubic response collector.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Geometry constants are shared with the upsample stage: a 2x bicubic beat
// carries two output rows of PIX_PER_ROW pixels, and four rows form a block.
package bicubic_rsp_collector_pkg;

    localparam int DEF_CHANNEL_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH    = 4;
    localparam int PIX_PER_ROW       = 4;
    localparam int ROWS_PER_BLK      = 4;
    localparam int BEAT_PIX          = 2 * PIX_PER_ROW;

    localparam logic [1:0] LAST_ROW  = 2'(ROWS_PER_BLK - 1);

    // Which half (row) of the head entry is currently presented.
    typedef enum logic {
        HALF_LO = 1'b0,   // lanes 0-3, even row of the pair
        HALF_HI = 1'b1    // lanes 4-7, odd row of the pair
    } half_e;

    // Row index within the 4-row block: the beat phase selects the row pair,
    // the half selects the row inside the pair.
    function automatic logic [1:0] row_index(input logic phase, input half_e half);
        return {phase, half};
    endfunction

endpackage

// File: rtl/bicubic_rsp_collector_fifo.sv
// Synchronous FIFO holding whole upsample beats (pixels plus phase bit).
// Latency: a push is visible at the head on the next cycle.
// Backpressure: push ignored while full, pop ignored while empty; no full pass-through.
//
// Ports: clk, rst (async active-high), push/wdata, pop, rdata (head entry),
//        full, empty. DEPTH must be a power of 2 so the pointers wrap naturally.
module bcci_sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic do_push;
    logic do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage is not reset; the head is only meaningful while not empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bicubic_rsp_collector.sv
// Buffers 2-row bicubic upsample beats and reissues them as one tagged row per beat.
// Latency: a beat pushed into an empty buffer in cycle N is presented in cycle N+1.
// Backpressure: bcci_rsp_ready depends only on buffer occupancy (drops when full), never on out_ready.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   bcci_rsp_valid/ready/data   input beats, lane k = [CW*k +: CW]; lanes 0-3 row A, 4-7 row B
//   out_valid/ready             output row handshake
//   out_data                    4 pixels of the row, pixel 0 in LSBs
//   out_row, out_last           row index 0..3 within the block, high on row 3
//   stall_cnt                   only with BCCI_COLLECT_STAT_EN: saturating count of
//                               cycles with out_valid & ~out_ready
module bicubic_rsp_collector
    import bicubic_rsp_collector_pkg::*;
#(
    parameter int CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 bcci_rsp_valid,
    output logic                                 bcci_rsp_ready,
    input  logic [BEAT_PIX*CHANNEL_WIDTH-1:0]    bcci_rsp_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [PIX_PER_ROW*CHANNEL_WIDTH-1:0] out_data,
    output logic [1:0]                           out_row,
    output logic                                 out_last
`ifdef BCCI_COLLECT_STAT_EN
    ,
    output logic [15:0]                          stall_cnt
`endif
);

    localparam int ROW_W   = PIX_PER_ROW * CHANNEL_WIDTH;
    localparam int BEAT_W  = BEAT_PIX * CHANNEL_WIDTH;
    localparam int ENTRY_W = BEAT_W + 1;

    logic               in_phase;
    half_e              half;
    logic               push;
    logic               fire;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;
    logic [BEAT_W-1:0]  head_pix;
    logic               head_phase;

    assign bcci_rsp_ready = ~fifo_full;
    assign push           = bcci_rsp_valid & bcci_rsp_ready;
    assign out_valid      = ~fifo_empty;
    assign fire           = out_valid & out_ready;
    // An entry retires only after its second row has been taken.
    assign pop            = fire & (half == HALF_HI);

    assign head_phase = head[ENTRY_W-1];
    assign head_pix   = head[BEAT_W-1:0];

    bcci_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({in_phase, bcci_rsp_data}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // in_phase tracks S1 (rows 0,1) vs S2 (rows 2,3) beats by simple alternation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_phase <= 1'b0;
            half     <= HALF_LO;
        end else begin
            if (push) begin
                in_phase <= ~in_phase;
            end
            if (fire) begin
                half <= (half == HALF_LO) ? HALF_HI : HALF_LO;
            end
        end
    end

    // Fields are forced to zero while empty so the unreset storage never leaks out.
    always_comb begin
        out_data = '0;
        out_row  = '0;
        if (out_valid) begin
            out_data = (half == HALF_HI) ? head_pix[ROW_W +: ROW_W] : head_pix[0 +: ROW_W];
            out_row  = row_index(head_phase, half);
        end
    end

    assign out_last = (out_row == LAST_ROW);

`ifdef BCCI_COLLECT_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bicubic_rsp_collector.sv
// Directed self-checking bench for bicubic_rsp_collector (CW=8, DEPTH=4).
// Covers reset, single/double beats, full backpressure, push-with-pop, async reset
// and, when BCCI_COLLECT_STAT_EN is defined, the stall counter.
module tb_bicubic_rsp_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bcci_rsp_valid = 1'b0;
    logic        bcci_rsp_ready;
    logic [63:0] bcci_rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  out_row;
    logic        out_last;
`ifdef BCCI_COLLECT_STAT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
    } row_t;

    logic [63:0] src_q[$];
    row_t        exp_q[$];

    always #5 clk = ~clk;

    bicubic_rsp_collector dut (
        .clk            (clk),
        .rst            (rst),
        .bcci_rsp_valid (bcci_rsp_valid),
        .bcci_rsp_ready (bcci_rsp_ready),
        .bcci_rsp_data  (bcci_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_row        (out_row),
        .out_last       (out_last)
`ifdef BCCI_COLLECT_STAT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Beat whose lane k holds b+k.
    function automatic logic [63:0] mk_beat(input logic [7:0] b);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = b + 8'(k);
        return r;
    endfunction

    // Queue both rows of beat b, expected in the block half given by phase.
    task automatic add_beat(input logic [7:0] b, input logic phase);
        row_t e;
        src_q.push_back(mk_beat(b));
        for (int h = 0; h < 2; h++) begin
            for (int k = 0; k < 4; k++) e.d[8*k +: 8] = b + 8'(4*h + k);
            e.r = {phase, h[0]};
            e.l = phase & h[0];
            exp_q.push_back(e);
        end
    endtask

    // One clock: drive next source beat, score a row taken this edge, advance.
    task automatic cyc();
        logic pushed;
        row_t e;
        bcci_rsp_valid = (src_q.size() != 0);
        bcci_rsp_data  = (src_q.size() != 0) ? src_q[0] : 64'd0;
        pushed = bcci_rsp_valid & bcci_rsp_ready;
        if (out_valid && out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("row_data", out_data, e.d);
            check("row_idx",  32'(out_row), 32'(e.r));
            check("row_last", 32'(out_last), 32'(e.l));
        end
        @(posedge clk);
        #1;
        if (pushed) void'(src_q.pop_front());
        bcci_rsp_valid = (src_q.size() != 0);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && n < budget) begin
            cyc();
            n++;
        end
        if (exp_q.size() != 0) check({tag, "_timeout_rows_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_q.delete();
        exp_q.delete();
        bcci_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. reset and idle
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", 32'(bcci_rsp_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_row",   32'(out_row), 32'd0);
        check("rst_last",  32'(out_last), 32'd0);
        check("rst_data",  out_data, 32'd0);
`ifdef BCCI_COLLECT_STAT_EN
        check("rst_stall", 32'(stall_cnt), 32'd0);
`endif

        // 2. single beat, one-cycle latency, two rows then empty
        out_ready = 1'b1;
        src_q.push_back(mk_beat(8'h01));
        cyc();
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_row0_data", out_data, 32'h04030201);
        check("t2_row0_idx", 32'(out_row), 32'd0);
        check("t2_row0_last", 32'(out_last), 32'd0);
        cyc();
        check("t2_row1_data", out_data, 32'h08070605);
        check("t2_row1_idx", 32'(out_row), 32'd1);
        cyc();
        check("t2_empty", 32'(out_valid), 32'd0);

        // 3. two back-to-back beats -> rows 0..3, last on row 3
        do_reset();
        out_ready = 1'b1;
        add_beat(8'h11, 1'b0);
        add_beat(8'h21, 1'b1);
        drain("t3", 20);
        check("t3_empty", 32'(out_valid), 32'd0);

        // 4. fill to DEPTH with output stalled, fifth beat held off
        out_ready = 1'b0;
        add_beat(8'h31, 1'b0);
        add_beat(8'h41, 1'b1);
        add_beat(8'h51, 1'b0);
        add_beat(8'h61, 1'b1);
        add_beat(8'h71, 1'b0);
        repeat (4) cyc();
        check("t4_full_ready", 32'(bcci_rsp_ready), 32'd0);
        check("t4_pending", 32'(src_q.size()), 32'd1);
        repeat (3) cyc();
        check("t4_still_full", 32'(bcci_rsp_ready), 32'd0);
        check("t4_pending2", 32'(src_q.size()), 32'd1);
        check("t4_stall_valid", 32'(out_valid), 32'd1);
        check("t4_stall_data", out_data, 32'h34333231);
        check("t4_stall_row", 32'(out_row), 32'd0);
        out_ready = 1'b1;
        drain("t4", 60);
        check("t4_empty", 32'(out_valid), 32'd0);
        check("t4_ready", 32'(bcci_rsp_ready), 32'd1);

        // 5. streaming: pushes coincide with pops of the head's second row
        add_beat(8'h81, 1'b1);
        add_beat(8'h91, 1'b0);
        add_beat(8'hA1, 1'b1);
        drain("t5", 30);
        check("t5_empty", 32'(out_valid), 32'd0);

        // 6. async reset with 3 entries queued
        out_ready = 1'b0;
        src_q.push_back(mk_beat(8'hB1));
        src_q.push_back(mk_beat(8'hC1));
        src_q.push_back(mk_beat(8'hD1));
        repeat (3) cyc();
        check("t6_queued", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_ready", 32'(bcci_rsp_ready), 32'd1);
        check("t6_rst_data", out_data, 32'd0);
`ifdef BCCI_COLLECT_STAT_EN
        check("t6_rst_stall", 32'(stall_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        src_q.delete();
        exp_q.delete();
        add_beat(8'hE1, 1'b0);
        cyc();
        repeat (20) cyc();
        check("t6_hold_data", out_data, 32'hE4E3E2E1);
        check("t6_hold_row", 32'(out_row), 32'd0);
`ifdef BCCI_COLLECT_STAT_EN
        check("t6_stall_cnt", 32'(stall_cnt), 32'd20);
`endif
        out_ready = 1'b1;
        drain("t6", 20);
        check("t6_empty", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
